float_rounder: RTL

- Final stage of the FPU multiply/add datapath.
- Consumes the unrounded result of the arithmetic stage: 24-bit normalized mantissa, 10-bit biased exponent, sign, round and sticky bits, final-result flag and invalid flag.
- Denormalizes tiny results, rounds per RISC-V rounding mode and packs an IEEE-754 binary32 word with exception flags.
- Load/ready handshake; variable latency.

---
 rtl/float_rounder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/float_rounder.sv
// float_rounder: denormalize, round and pack a binary32 FPU result.
// Build option FAST_DENORM_EN selects a single-cycle barrel denormalizer.
module float_rounder #(
    parameter int MAX_SHIFT = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [23:0] man_in,
    input  logic [9:0]  exp_in,
    input  logic        sgn_in,
    input  logic        round_bit,
    input  logic        sticky_bit,
    input  logic        final_res,
    input  logic        IV_in,
    input  logic [2:0]  rm,
    output logic [31:0] float_out,
    output logic        IV,
    output logic        OF,
    output logic        UF,
    output logic        NX,
    output logic        busy,
    output logic        ready
);

    localparam int CW = $clog2(MAX_SHIFT + 1);
    localparam logic signed [10:0] MAXS = 11'(MAX_SHIFT);
    localparam logic [CW-1:0] MAXK = CW'(MAX_SHIFT);

    typedef enum logic [1:0] {IDLE, DENORM, ROUND} state_t;

    state_t state_q, state_d;

    logic [23:0] man_q;
    logic [9:0]  exp_q;
    logic        sgn_q, rnd_q, stk_q, fin_q, iv_q, tiny_q;
    logic [2:0]  rm_q;

    logic               is_norm;
    logic signed [10:0] k_full;
    logic [CW-1:0]      k;

    assign is_norm = final_res | (~exp_in[9] & (|exp_in));
    assign k_full  = 11'sd1 - $signed({exp_in[9], exp_in});
    assign k       = (k_full > MAXS) ? MAXK : k_full[CW-1:0];

`ifdef FAST_DENORM_EN
    logic [49:0] sh_full;
    assign sh_full = {man_in, round_bit, 25'd0} >> k;
`else
    logic [CW-1:0] cnt_q;
`endif

    // Rounding and packing, evaluated from the working registers
    logic               inc, nx, ovf, to_inf;
    logic [24:0]        sum;
    logic [23:0]        rman;
    logic signed [10:0] rexp;
    logic [31:0]        res;
    logic [3:0]         res_flags;

    always_comb begin
        inc = 1'b0;
        to_inf = 1'b1;
        case (rm_q)
            3'b001: begin
                inc = 1'b0;
                to_inf = 1'b0;
            end
            3'b010: begin
                inc = sgn_q & (rnd_q | stk_q);
                to_inf = sgn_q;
            end
            3'b011: begin
                inc = ~sgn_q & (rnd_q | stk_q);
                to_inf = ~sgn_q;
            end
            3'b100: inc = rnd_q;
            default: inc = rnd_q & (stk_q | man_q[0]);
        endcase

        sum  = {1'b0, man_q} + 25'(inc);
        rman = sum[24] ? 24'h800000 : sum[23:0];
        rexp = $signed({exp_q[9], exp_q}) + 11'(sum[24]);
        nx   = rnd_q | stk_q;
        ovf  = rexp > 11'sd254;

        if (fin_q) begin
            res = {sgn_q, exp_q[7:0], man_q[22:0]};
            res_flags = {iv_q, 3'b000};
        end else if (ovf) begin
            res = to_inf ? {sgn_q, 8'hFF, 23'd0}
                         : {sgn_q, 8'hFE, 23'h7FFFFF};
            res_flags = {iv_q, 1'b1, tiny_q & nx, 1'b1};
        end else begin
            res = {sgn_q, rman[23] ? rexp[7:0] : 8'd0, rman[22:0]};
            res_flags = {iv_q, 1'b0, tiny_q & nx, nx};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = IDLE;
`ifdef FAST_DENORM_EN
            DENORM: state_d = ROUND;
`else
            DENORM: if (cnt_q == CW'(1)) state_d = ROUND;
`endif
            ROUND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
`ifdef FAST_DENORM_EN
            state_d = ROUND;
`else
            state_d = is_norm ? ROUND : DENORM;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            man_q     <= '0;
            exp_q     <= '0;
            sgn_q     <= 1'b0;
            rnd_q     <= 1'b0;
            stk_q     <= 1'b0;
            fin_q     <= 1'b0;
            iv_q      <= 1'b0;
            tiny_q    <= 1'b0;
            rm_q      <= '0;
`ifndef FAST_DENORM_EN
            cnt_q     <= '0;
`endif
            float_out <= '0;
            IV        <= 1'b0;
            OF        <= 1'b0;
            UF        <= 1'b0;
            NX        <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
        end else if (load) begin
            sgn_q <= sgn_in;
            rm_q  <= rm;
            fin_q <= final_res;
            iv_q  <= IV_in;
            busy  <= 1'b1;
            ready <= 1'b0;
            if (is_norm) begin
                man_q  <= man_in;
                exp_q  <= exp_in;
                rnd_q  <= round_bit;
                stk_q  <= sticky_bit;
                tiny_q <= 1'b0;
            end else begin
                tiny_q <= 1'b1;
`ifdef FAST_DENORM_EN
                man_q <= sh_full[49:26];
                rnd_q <= sh_full[25];
                stk_q <= sticky_bit | (|sh_full[24:0]);
                exp_q <= 10'd1;
`else
                man_q <= man_in;
                exp_q <= exp_in;
                rnd_q <= round_bit;
                stk_q <= sticky_bit;
                cnt_q <= k;
`endif
            end
        end else begin
            case (state_q)
`ifndef FAST_DENORM_EN
                DENORM: begin
                    man_q <= {1'b0, man_q[23:1]};
                    rnd_q <= man_q[0];
                    stk_q <= stk_q | rnd_q;
                    cnt_q <= cnt_q - CW'(1);
                    // saturated shifts never walk exp all the way up
                    exp_q <= (cnt_q == CW'(1)) ? 10'd1 : exp_q + 10'd1;
                end
`endif
                ROUND: begin
                    float_out <= res;
                    {IV, OF, UF, NX} <= res_flags;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ready <= 1'b0;
            endcase
        end
    end

endmodule
